// File: rtl/acc_pkg.sv
// Shared definitions for the matrix accumulator sequencer and its clock gate.
// Holds the sequencer state encoding, default sizing and the control
// register values that start and end an accumulation job.
package acc_pkg;

  // Default width of the load-beat and pass counters
  localparam int unsigned CNT_W_DEF    = 8;
  // Default per-pass watchdog budget, in cycles
  localparam int unsigned WDOG_CYC_DEF = 255;

  // Control register values written over APB; the clock gate decodes the same values
  localparam logic [31:0] ACC_EN  = 32'h0000_0001;
  localparam logic [31:0] ACC_END = 32'h0000_0002;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_LAUNCH = 3'd2,
    ST_WAIT   = 3'd3,
    ST_SHIFT  = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERR    = 3'd6
  } acc_state_e;

endpackage

// File: rtl/acc_wdog.sv
// Per-pass watchdog: a loadable down-counter.
//   clk, rst    : clock, async active-high reset
//   clr_i       : force the count to zero (highest priority)
//   load_i      : reload the full budget of WDOG_CYC cycles
//   en_i        : count down one cycle (saturates at zero)
//   expired_c   : combinational, high while the current cycle is the last one of the budget
module acc_wdog
  import acc_pkg::*;
#(
  parameter int unsigned WDOG_CYC = WDOG_CYC_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic load_i,
  input  logic en_i,
  output logic expired_c
);

  localparam int unsigned WD_W = $clog2(WDOG_CYC + 1);

  logic [WD_W-1:0] cnt_q;
  logic [WD_W-1:0] cnt_d;

  // Next count: clear beats load beats decrement
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = WD_W'(WDOG_CYC);
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - WD_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A count of one means this is the WDOG_CYC-th counted cycle since the reload
  assign expired_c = (cnt_q <= WD_W'(1));

endmodule

// File: rtl/acc_seq_ctrl.sv
// Sequencer for the matrix accumulator datapath: counts operand load beats,
// then runs ACC_ITER ALU passes separated by operand shifts, stalling APB
// while computing and pulsing acc_finish_o at the end of a job.
//   clk, rst         : gated accelerator clock, async active-high reset
//   start_i          : job start pulse (honoured in IDLE and ERR only)
//   abort_i          : synchronous abort back to IDLE
//   wr_beat_i        : accepted operand write beat
//   cal_finish_i     : datapath finished the current ALU pass
//   load_en_o        : datapath load enable
//   alu_en_o         : one-cycle ALU pass launch
//   shift_data_en_o  : one-cycle operand shift between passes
//   acc_counter_o    : completed pass count
//   pready_o         : APB ready, low while computing
//   busy_o           : job in progress
//   acc_finish_o     : one-cycle job complete pulse
//   err_o            : sticky watchdog error
module acc_seq_ctrl
  import acc_pkg::*;
#(
  parameter int unsigned N_LOAD   = 16,
  parameter int unsigned ACC_ITER = 4,
  parameter int unsigned CNT_W    = CNT_W_DEF,
  parameter int unsigned WDOG_CYC = WDOG_CYC_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic             wr_beat_i,
  input  logic             cal_finish_i,
  output logic             load_en_o,
  output logic             alu_en_o,
  output logic             shift_data_en_o,
  output logic [CNT_W-1:0] acc_counter_o,
  output logic             pready_o,
  output logic             busy_o,
  output logic             acc_finish_o,
  output logic             err_o
);

  localparam logic [CNT_W-1:0] LOAD_TERM = CNT_W'(N_LOAD);
  localparam logic [CNT_W-1:0] ACC_TERM  = CNT_W'(ACC_ITER);

  acc_state_e       state_q, state_d;
  logic [CNT_W-1:0] load_cnt_q, load_cnt_d;
  logic [CNT_W-1:0] acc_cnt_q, acc_cnt_d;
  logic             err_q, err_d;
  logic             load_en_q, load_en_d;
  logic             alu_en_q, alu_en_d;
  logic             shift_en_q, shift_en_d;
  logic             pready_q, pready_d;
  logic             busy_q, busy_d;
  logic             finish_q, finish_d;

  logic             wdog_clr;
  logic             wdog_load;
  logic             wdog_en;
  logic             wdog_expired_c;

  acc_wdog #(
    .WDOG_CYC (WDOG_CYC)
  ) u_wdog (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (wdog_clr),
    .load_i    (wdog_load),
    .en_i      (wdog_en),
    .expired_c (wdog_expired_c)
  );

  // The watchdog only runs while waiting on the datapath
  assign wdog_en = (state_q == ST_WAIT);

  // Next state, counters and error flag
  always_comb begin
    state_d    = state_q;
    load_cnt_d = load_cnt_q;
    acc_cnt_d  = acc_cnt_q;
    err_d      = err_q;
    wdog_clr   = 1'b0;
    wdog_load  = 1'b0;

    if (abort_i && (state_q != ST_IDLE)) begin
      // Abort outranks every other event and leaves the pass count visible
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_ERR: begin
          if (start_i) begin
            state_d    = ST_LOAD;
            load_cnt_d = '0;
            acc_cnt_d  = '0;
            err_d      = 1'b0;
            wdog_clr   = 1'b1;
          end
        end
        ST_LOAD: begin
          if (wr_beat_i && (load_cnt_q != LOAD_TERM)) begin
            load_cnt_d = load_cnt_q + CNT_W'(1);
            if (load_cnt_d == LOAD_TERM) begin
              state_d = ST_LAUNCH;
            end
          end
        end
        ST_LAUNCH: begin
          wdog_load = 1'b1;
          state_d   = ST_WAIT;
        end
        ST_WAIT: begin
          // A finished pass wins over a watchdog expiring in the same cycle
          if (cal_finish_i) begin
            if (acc_cnt_q != ACC_TERM) begin
              acc_cnt_d = acc_cnt_q + CNT_W'(1);
            end
            state_d = (acc_cnt_d == ACC_TERM) ? ST_DONE : ST_SHIFT;
          end else if (wdog_expired_c) begin
            state_d = ST_ERR;
            err_d   = 1'b1;
          end
        end
        ST_SHIFT: state_d = ST_LAUNCH;
        ST_DONE:  state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state so they line up with the state register
  always_comb begin
    load_en_d  = (state_d == ST_LOAD);
    alu_en_d   = (state_d == ST_LAUNCH);
    shift_en_d = (state_d == ST_SHIFT);
    finish_d   = (state_d == ST_DONE);
    busy_d     = (state_d == ST_LOAD) || (state_d == ST_LAUNCH) || (state_d == ST_WAIT) ||
                 (state_d == ST_SHIFT) || (state_d == ST_DONE);
    pready_d   = !((state_d == ST_LAUNCH) || (state_d == ST_WAIT) || (state_d == ST_SHIFT));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      load_cnt_q <= '0;
      acc_cnt_q  <= '0;
      err_q      <= 1'b0;
      load_en_q  <= 1'b0;
      alu_en_q   <= 1'b0;
      shift_en_q <= 1'b0;
      pready_q   <= 1'b1;
      busy_q     <= 1'b0;
      finish_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      load_cnt_q <= load_cnt_d;
      acc_cnt_q  <= acc_cnt_d;
      err_q      <= err_d;
      load_en_q  <= load_en_d;
      alu_en_q   <= alu_en_d;
      shift_en_q <= shift_en_d;
      pready_q   <= pready_d;
      busy_q     <= busy_d;
      finish_q   <= finish_d;
    end
  end

  assign load_en_o       = load_en_q;
  assign alu_en_o        = alu_en_q;
  assign shift_data_en_o = shift_en_q;
  assign acc_counter_o   = acc_cnt_q;
  assign pready_o        = pready_q;
  assign busy_o          = busy_q;
  assign acc_finish_o    = finish_q;
  assign err_o           = err_q;

endmodule

// File: tb/tb_acc_seq_ctrl.sv
// Directed bench for acc_seq_ctrl with default parameters
// (N_LOAD=16, ACC_ITER=4, CNT_W=8, WDOG_CYC=255).
module tb_acc_seq_ctrl;
  import acc_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start_i = 1'b0;
  logic       abort_i = 1'b0;
  logic       wr_beat_i = 1'b0;
  logic       cal_finish_i = 1'b0;
  logic       load_en_o;
  logic       alu_en_o;
  logic       shift_data_en_o;
  logic [7:0] acc_counter_o;
  logic       pready_o;
  logic       busy_o;
  logic       acc_finish_o;
  logic       err_o;

  int errors = 0;
  int checks = 0;

  acc_seq_ctrl #(
    .N_LOAD   (16),
    .ACC_ITER (4),
    .CNT_W    (8),
    .WDOG_CYC (255)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .start_i         (start_i),
    .abort_i         (abort_i),
    .wr_beat_i       (wr_beat_i),
    .cal_finish_i    (cal_finish_i),
    .load_en_o       (load_en_o),
    .alu_en_o        (alu_en_o),
    .shift_data_en_o (shift_data_en_o),
    .acc_counter_o   (acc_counter_o),
    .pready_o        (pready_o),
    .busy_o          (busy_o),
    .acc_finish_o    (acc_finish_o),
    .err_o           (err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         reps;
    logic       st, ab, wr, cal;
    logic       ld, alu, sh;
    logic [7:0] acc;
    logic       rdy, busy, fin, err;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(int reps, logic st, logic ab, logic wr, logic cal,
                              logic ld, logic alu, logic sh, logic [7:0] acc,
                              logic rdy, logic busy, logic fin, logic err);
    vec_t v;
    v.reps = reps; v.st = st; v.ab = ab; v.wr = wr; v.cal = cal;
    v.ld = ld; v.alu = alu; v.sh = sh; v.acc = acc;
    v.rdy = rdy; v.busy = busy; v.fin = fin; v.err = err;
    return v;
  endfunction

  // Compare all outputs at once: {load,alu,shift,acc[7:0],pready,busy,finish,err}
  task automatic expect_o(input string tag, input logic ld, input logic alu, input logic sh,
                          input logic [7:0] acc, input logic rdy, input logic busy,
                          input logic fin, input logic err);
    logic [14:0] got;
    logic [14:0] exp;
    got = {load_en_o, alu_en_o, shift_data_en_o, acc_counter_o, pready_o, busy_o, acc_finish_o, err_o};
    exp = {ld, alu, sh, acc, rdy, busy, fin, err};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got ld=%b alu=%b sh=%b acc=%0d rdy=%b busy=%b fin=%b err=%b, want ld=%b alu=%b sh=%b acc=%0d rdy=%b busy=%b fin=%b err=%b",
               tag, got[14], got[13], got[12], got[11:4], got[3], got[2], got[1], got[0],
               ld, alu, sh, acc, rdy, busy, fin, err);
    end
  endtask

  // Drive one cycle of inputs on the falling edge, then sample just after the rising edge
  task automatic cyc(input logic st, input logic ab, input logic wr, input logic cal);
    @(negedge clk);
    start_i = st; abort_i = ab; wr_beat_i = wr; cal_finish_i = cal;
    @(posedge clk);
    #1;
  endtask

  // Start a job and feed all 16 beats; leaves the DUT in LAUNCH
  task automatic load_job();
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 16; i++) cyc(0, 0, 1, 0);
  endtask

  initial begin
    // Reset
    #1 rst = 1'b1;
    #2;
    expect_o("reset_async", 0, 0, 0, 8'd0, 1, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    expect_o("reset_release", 0, 0, 0, 8'd0, 1, 0, 0, 0);

    // Job A: full zero-wait job with ignored events sprinkled in
    //          reps st ab wr cal   ld alu sh acc  rdy busy fin err
    vq.push_back(mk(1, 0, 0, 1, 1,  0, 0, 0, 8'd0, 1, 0, 0, 0));  // idle ignores beat/cal
    vq.push_back(mk(1, 0, 1, 0, 0,  0, 0, 0, 8'd0, 1, 0, 0, 0));  // abort in idle is a no-op
    vq.push_back(mk(1, 1, 0, 0, 0,  1, 0, 0, 8'd0, 1, 1, 0, 0));  // start -> LOAD
    vq.push_back(mk(1, 0, 0, 0, 1,  1, 0, 0, 8'd0, 1, 1, 0, 0));  // cal in LOAD ignored
    vq.push_back(mk(15, 0, 0, 1, 0, 1, 0, 0, 8'd0, 1, 1, 0, 0));  // beats 1..15
    vq.push_back(mk(1, 1, 0, 1, 0,  0, 1, 0, 8'd0, 0, 1, 0, 0));  // beat 16 -> LAUNCH, start ignored
    vq.push_back(mk(1, 0, 0, 0, 0,  0, 0, 0, 8'd0, 0, 1, 0, 0));  // WAIT
    vq.push_back(mk(1, 0, 0, 0, 1,  0, 0, 1, 8'd1, 0, 1, 0, 0));  // pass 1 -> SHIFT
    vq.push_back(mk(1, 0, 0, 0, 1,  0, 1, 0, 8'd1, 0, 1, 0, 0));  // LAUNCH, cal in SHIFT ignored
    vq.push_back(mk(1, 1, 0, 0, 0,  0, 0, 0, 8'd1, 0, 1, 0, 0));  // WAIT, start ignored
    vq.push_back(mk(1, 0, 0, 0, 1,  0, 0, 1, 8'd2, 0, 1, 0, 0));  // pass 2
    vq.push_back(mk(1, 0, 0, 0, 0,  0, 1, 0, 8'd2, 0, 1, 0, 0));
    vq.push_back(mk(1, 0, 0, 0, 0,  0, 0, 0, 8'd2, 0, 1, 0, 0));
    vq.push_back(mk(1, 1, 0, 0, 1,  0, 0, 1, 8'd3, 0, 1, 0, 0));  // pass 3, start ignored
    vq.push_back(mk(1, 0, 0, 0, 0,  0, 1, 0, 8'd3, 0, 1, 0, 0));
    vq.push_back(mk(1, 0, 0, 0, 0,  0, 0, 0, 8'd3, 0, 1, 0, 0));
    vq.push_back(mk(1, 0, 0, 0, 1,  0, 0, 0, 8'd4, 1, 1, 1, 0));  // pass 4 -> DONE pulse
    vq.push_back(mk(1, 0, 0, 0, 0,  0, 0, 0, 8'd4, 1, 0, 0, 0));  // IDLE, count held
    vq.push_back(mk(1, 0, 0, 0, 1,  0, 0, 0, 8'd4, 1, 0, 0, 0));
    // Job B: 20 beats, then abort in WAIT after pass 2
    vq.push_back(mk(1, 1, 0, 0, 0,  1, 0, 0, 8'd0, 1, 1, 0, 0));  // start clears count
    vq.push_back(mk(15, 0, 0, 1, 0, 1, 0, 0, 8'd0, 1, 1, 0, 0));
    vq.push_back(mk(1, 0, 0, 1, 0,  0, 1, 0, 8'd0, 0, 1, 0, 0));  // beat 16 -> LAUNCH
    vq.push_back(mk(4, 0, 0, 1, 0,  0, 0, 0, 8'd0, 0, 1, 0, 0));  // beats 17..20 ignored
    vq.push_back(mk(1, 0, 0, 0, 1,  0, 0, 1, 8'd1, 0, 1, 0, 0));
    vq.push_back(mk(1, 0, 0, 0, 0,  0, 1, 0, 8'd1, 0, 1, 0, 0));
    vq.push_back(mk(1, 0, 0, 0, 0,  0, 0, 0, 8'd1, 0, 1, 0, 0));
    vq.push_back(mk(1, 0, 0, 0, 1,  0, 0, 1, 8'd2, 0, 1, 0, 0));  // pass 2 done
    vq.push_back(mk(1, 0, 0, 0, 0,  0, 1, 0, 8'd2, 0, 1, 0, 0));
    vq.push_back(mk(1, 0, 0, 0, 0,  0, 0, 0, 8'd2, 0, 1, 0, 0));  // WAIT
    vq.push_back(mk(1, 1, 1, 0, 1,  0, 0, 0, 8'd2, 1, 0, 0, 0));  // abort beats cal/start
    vq.push_back(mk(1, 0, 0, 0, 0,  0, 0, 0, 8'd2, 1, 0, 0, 0));

    foreach (vq[k]) begin
      for (int r = 0; r < vq[k].reps; r++) begin
        cyc(vq[k].st, vq[k].ab, vq[k].wr, vq[k].cal);
        expect_o($sformatf("vec%0d.%0d", k, r), vq[k].ld, vq[k].alu, vq[k].sh, vq[k].acc,
                 vq[k].rdy, vq[k].busy, vq[k].fin, vq[k].err);
      end
    end

    // Watchdog: no cal_finish for 255 WAIT cycles
    load_job();
    expect_o("wd_launch", 0, 1, 0, 8'd0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0);
    expect_o("wd_wait", 0, 0, 0, 8'd0, 0, 1, 0, 0);
    for (int i = 1; i < 255; i++) begin
      cyc(0, 0, 0, 0);
      if (i == 1 || i == 254) expect_o($sformatf("wd_hold%0d", i), 0, 0, 0, 8'd0, 0, 1, 0, 0);
    end
    cyc(0, 0, 0, 0);
    expect_o("wd_expire", 0, 0, 0, 8'd0, 1, 0, 0, 1);
    cyc(0, 0, 1, 1);
    expect_o("err_sticky", 0, 0, 0, 8'd0, 1, 0, 0, 1);

    // Restart from ERR clears the error; first pass finishes on the expiry cycle
    load_job();
    expect_o("restart_launch", 0, 1, 0, 8'd0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0);
    for (int i = 1; i < 255; i++) cyc(0, 0, 0, 0);
    expect_o("tie_pre", 0, 0, 0, 8'd0, 0, 1, 0, 0);
    cyc(0, 0, 0, 1);
    expect_o("tie_cal_wins", 0, 0, 1, 8'd1, 0, 1, 0, 0);
    cyc(0, 0, 0, 0);
    expect_o("tie_launch", 0, 1, 0, 8'd1, 0, 1, 0, 0);
    cyc(0, 0, 0, 0);
    expect_o("tie_wait", 0, 0, 0, 8'd1, 0, 1, 0, 0);

    // Async reset between clock edges during WAIT
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    expect_o("rst_mid_wait", 0, 0, 0, 8'd0, 1, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    cyc(0, 0, 1, 1);
    expect_o("rst_idle", 0, 0, 0, 8'd0, 1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    expect_o("rst_restart", 1, 0, 0, 8'd0, 1, 1, 0, 0);
    cyc(0, 1, 0, 0);
    expect_o("abort_load", 0, 0, 0, 8'd0, 1, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
